// File: rtl/drive_link_ctrl.sv
// Car drive/link controller: long-press power, manual-drive FSM, mode mux,
// valid/ready frame issue toward the UART core and a detector watchdog.
//
// state        | meaning
// NOT_STARTING | engine idle, waiting for clutch+throttle
// STARTING     | engine running with clutch engaged, gear may be changed
// MOVING       | driving in the gear latched while the clutch was held

module drive_link_ctrl #(
    parameter int POWER_HOLD_CYC = 100_000_000,
    parameter int TX_PERIOD      = 1_000_000,
    parameter int STALE_CYC      = 50_000_000,
    parameter int N_DET          = 4
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [1:0]       global_state,
    input  logic             power_on,
    input  logic             power_off,
    input  logic             clutch,
    input  logic             throttle,
    input  logic             brake,
    input  logic             rgs,
    input  logic             left,
    input  logic             right,
    input  logic [1:0]       auto_state,
    input  logic [3:0]       auto_moving,
    input  logic             place,
    input  logic             destroy,
    input  logic             tx_ready,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic [N_DET-1:0] detector,
    output logic             power_light,
    output logic [2:0]       state_light,
    output logic [3:0]       moving_light,
    output logic             turn_left_light,
    output logic             turn_right_light
);

    localparam int HW = (POWER_HOLD_CYC > 1) ? $clog2(POWER_HOLD_CYC) : 1;
    localparam int PW = (TX_PERIOD > 1) ? $clog2(TX_PERIOD) : 1;
    localparam int SW = (STALE_CYC > 1) ? $clog2(STALE_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(POWER_HOLD_CYC - 1);
    localparam logic [PW-1:0] PER_LAST   = PW'(TX_PERIOD - 1);
    localparam logic [SW-1:0] STALE_LAST = SW'(STALE_CYC - 1);

    typedef enum logic [1:0] {
        NOT_STARTING = 2'd0,
        STARTING     = 2'd1,
        MOVING       = 2'd2
    } man_state_t;

    logic [HW-1:0] hold_cnt;
    logic          power;
    man_state_t    man_state, man_next;
    logic          gear, gear_next;
    logic          fault;
    logic          man_active;
    logic [3:0]    man_moving;
    logic          man_turn_l, man_turn_r;
    logic [1:0]    disp_code;
    logic [3:0]    disp_moving;
    logic          disp_turn_l, disp_turn_r;
    logic [5:0]    tuple, tuple_prev;
    logic [PW-1:0] per_cnt;
    logic          per_hit, trigger, accept, issue, owed;
    logic [SW-1:0] wd_cnt;
    logic          unused_rx;

    assign man_active = (global_state == 2'b00) && power;

    // Long-press counter saturates so a held button keeps satisfying the hold condition.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst)                       hold_cnt <= '0;
        else if (!power_on)             hold_cnt <= '0;
        else if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HW'(1);
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst)                                     power <= 1'b0;
        else if (power_off || fault)                  power <= 1'b0;
        else if (power_on && (hold_cnt == HOLD_LAST)) power <= 1'b1;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            man_state <= NOT_STARTING;
            gear      <= 1'b0;
        end else begin
            man_state <= man_next;
            gear      <= gear_next;
        end
    end

    always_comb begin
        man_next  = man_state;
        gear_next = gear;
        fault     = 1'b0;
        if (man_active) begin
            if (clutch) gear_next = rgs;
            if (brake) begin
                man_next = NOT_STARTING;
            end else begin
                case (man_state)
                    NOT_STARTING: begin
                        if (throttle && clutch) man_next = STARTING;
                        else if (throttle)      fault    = 1'b1;
                    end
                    STARTING: begin
                        if (throttle && !clutch) man_next = MOVING;
                    end
                    MOVING: begin
                        if (!clutch && (rgs != gear)) fault    = 1'b1;
                        else if (clutch || !throttle) man_next = STARTING;
                    end
                    default: man_next = NOT_STARTING;
                endcase
            end
        end
        if (!man_active || fault || power_off) man_next = NOT_STARTING;
    end

    always_comb begin
        man_moving = (man_next == MOVING) ? {right, left, gear_next, ~gear_next} : 4'b0000;
        man_turn_l = (man_next != NOT_STARTING) && left;
        man_turn_r = (man_next != NOT_STARTING) && right;
    end

    // Display source: manual tracks its FSM, semi/auto are sampled, hold freezes everything.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            disp_code   <= 2'b00;
            disp_moving <= 4'b0000;
            disp_turn_l <= 1'b0;
            disp_turn_r <= 1'b0;
        end else begin
            case (global_state)
                2'b00: begin
                    disp_code   <= man_next;
                    disp_moving <= man_moving;
                    disp_turn_l <= man_turn_l;
                    disp_turn_r <= man_turn_r;
                end
                2'b01, 2'b10: begin
                    disp_code   <= auto_state;
                    disp_moving <= auto_moving;
                    disp_turn_l <= 1'b0;
                    disp_turn_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (disp_code)
            2'd0:    state_light = 3'b001;
            2'd1:    state_light = 3'b010;
            2'd2:    state_light = 3'b100;
            default: state_light = 3'b111;
        endcase
        if (!power) state_light = 3'b000;
    end

    assign power_light      = power;
    assign moving_light     = power ? disp_moving : 4'b0000;
    assign turn_left_light  = power && disp_turn_l;
    assign turn_right_light = power && disp_turn_r;

    assign tuple   = {destroy, place, moving_light};
    assign per_hit = (per_cnt == '0);
    assign trigger = (tuple != tuple_prev) || per_hit;
    assign accept  = tx_valid && tx_ready;
    assign issue   = (trigger || owed) && (!tx_valid || accept);

    // A trigger that cannot issue leaves a debt; the debt frame samples the tuple when it goes out.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            tuple_prev <= 6'd0;
            per_cnt    <= PER_LAST;
            owed       <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'd0;
        end else begin
            tuple_prev <= tuple;
            if (issue || per_hit) per_cnt <= PER_LAST;
            else                  per_cnt <= per_cnt - PW'(1);
            if (issue) begin
                tx_valid <= 1'b1;
                tx_data  <= {2'b10, tuple};
                owed     <= 1'b0;
            end else begin
                if (accept)  tx_valid <= 1'b0;
                if (trigger) owed     <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            detector <= '0;
            wd_cnt   <= STALE_LAST;
        end else if (rx_valid) begin
            detector <= rx_data[N_DET-1:0];
            wd_cnt   <= STALE_LAST;
        end else if (wd_cnt == '0) begin
            detector <= '1;
        end else begin
            wd_cnt <= wd_cnt - SW'(1);
        end
    end

    // Bits above the detector channels carry nothing for this block.
    assign unused_rx = ^rx_data;

endmodule

// File: tb/tb_drive_link_ctrl.sv
// Bench for drive_link_ctrl: vector table for power/manual/mode behaviour, hand sequences
// for framer and watchdog corners, then randomized traffic against a behavioural model.

module tb_drive_link_ctrl;

    localparam int HOLD  = 8;
    localparam int PER   = 32;
    localparam int STALE = 16;
    localparam int ND    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    global_state;
    logic          power_on, power_off, clutch, throttle, brake, rgs, left, right;
    logic [1:0]    auto_state;
    logic [3:0]    auto_moving;
    logic          place, destroy, tx_ready, rx_valid;
    logic [7:0]    rx_data;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [ND-1:0] detector;
    logic          power_light;
    logic [2:0]    state_light;
    logic [3:0]    moving_light;
    logic          turn_left_light, turn_right_light;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    drive_link_ctrl #(
        .POWER_HOLD_CYC(HOLD), .TX_PERIOD(PER), .STALE_CYC(STALE), .N_DET(ND)
    ) dut (
        .sys_clk(clk), .rst(rst), .global_state(global_state),
        .power_on(power_on), .power_off(power_off), .clutch(clutch), .throttle(throttle),
        .brake(brake), .rgs(rgs), .left(left), .right(right),
        .auto_state(auto_state), .auto_moving(auto_moving),
        .place(place), .destroy(destroy), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .detector(detector),
        .power_light(power_light), .state_light(state_light), .moving_light(moving_light),
        .turn_left_light(turn_left_light), .turn_right_light(turn_right_light)
    );

    typedef struct {
        int         reps;
        logic [1:0] gs;
        logic       pon, poff, cl, thr, br, rg, l, r;
        logic [1:0] as;
        logic [3:0] am;
        logic       pw;
        logic [2:0] sl;
        logic [3:0] ml;
        logic       tl, tr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int reps, logic [1:0] gs, logic pon, logic poff, logic cl,
                                logic thr, logic br, logic rg, logic l, logic r,
                                logic [1:0] as, logic [3:0] am, logic pw, logic [2:0] sl,
                                logic [3:0] ml, logic tl, logic tr);
        vec_t v;
        v.reps = reps; v.gs = gs; v.pon = pon; v.poff = poff; v.cl = cl; v.thr = thr;
        v.br = br; v.rg = rg; v.l = l; v.r = r; v.as = as; v.am = am;
        v.pw = pw; v.sl = sl; v.ml = ml; v.tl = tl; v.tr = tr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        global_state = 2'b00; power_on = 0; power_off = 0; clutch = 0; throttle = 0;
        brake = 0; rgs = 0; left = 0; right = 0; auto_state = 0; auto_moving = 0;
        place = 0; destroy = 0; tx_ready = 1; rx_valid = 0; rx_data = 0;
    endtask

    task automatic do_reset;
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    // Behavioural model: spec rules stated in terms of elapsed cycles and events.
    int         m_press, m_since, m_quiet;
    int         m_mst;
    bit         m_power, m_gear, m_tl, m_tr, m_pend, m_owed;
    bit [1:0]   m_code;
    bit [3:0]   m_mov, m_det;
    bit [5:0]   m_last;
    bit [7:0]   m_data;

    function automatic logic [2:0] lamp(input logic [1:0] c);
        return (c == 2'd3) ? 3'b111 : 3'(1 << c);
    endfunction

    task automatic m_reset;
        m_press = 0; m_since = 0; m_quiet = 0; m_mst = 0;
        m_power = 0; m_gear = 0; m_tl = 0; m_tr = 0; m_pend = 0; m_owed = 0;
        m_code = 0; m_mov = 0; m_det = 0; m_last = 0; m_data = 0;
    endtask

    task automatic m_step;
        bit [5:0] tup;
        bit       hit, trig, acc, free, active, flt, ngear, np;
        int       nst;
        tup  = {destroy, place, (m_power ? m_mov : 4'b0)};
        hit  = (m_since == PER - 1);
        trig = (tup != m_last) || hit;
        acc  = m_pend && tx_ready;
        free = !m_pend || acc;
        if ((trig || m_owed) && free) begin
            m_pend = 1; m_data = {2'b10, tup}; m_owed = 0; m_since = 0;
        end else begin
            if (acc)  m_pend = 0;
            if (trig) m_owed = 1;
            m_since = hit ? 0 : m_since + 1;
        end
        m_last = tup;

        if (rx_valid) begin
            m_det = rx_data[3:0]; m_quiet = 0;
        end else if (m_quiet >= STALE - 1) m_det = 4'hF;
        else m_quiet++;

        active = (global_state == 2'b00) && m_power;
        flt = 0; nst = m_mst; ngear = m_gear;
        if (active) begin
            if (clutch) ngear = rgs;
            if (brake) nst = 0;
            else if (m_mst == 0) begin
                if (throttle && clutch) nst = 1;
                else if (throttle) flt = 1;
            end else if (m_mst == 1) begin
                if (throttle && !clutch) nst = 2;
            end else begin
                if (!clutch && rgs != m_gear) flt = 1;
                else if (clutch || !throttle) nst = 1;
            end
        end
        if (!active || flt || power_off) nst = 0;

        case (global_state)
            2'b00: begin
                m_code = 2'(nst);
                m_mov  = (nst == 2) ? {right, left, ngear, !ngear} : 4'b0;
                m_tl   = left && nst != 0;
                m_tr   = right && nst != 0;
            end
            2'b01, 2'b10: begin
                m_code = auto_state; m_mov = auto_moving; m_tl = 0; m_tr = 0;
            end
            default: ;
        endcase

        if (power_off || flt) np = 0;
        else if (power_on && m_press >= HOLD - 1) np = 1;
        else np = m_power;
        m_press = power_on ? ((m_press < 1000000) ? m_press + 1 : m_press) : 0;
        m_power = np; m_mst = nst; m_gear = ngear;
    endtask

    task automatic randomize_inputs;
        if ($urandom_range(0, 7) == 0)  power_on = ~power_on;
        power_off = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 4) == 0)  clutch = ~clutch;
        if ($urandom_range(0, 4) == 0)  throttle = ~throttle;
        brake = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 11) == 0) rgs = ~rgs;
        if ($urandom_range(0, 5) == 0)  left = ~left;
        if ($urandom_range(0, 5) == 0)  right = ~right;
        if ($urandom_range(0, 24) == 0) global_state = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0)  auto_state = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0)  auto_moving = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 19) == 0) place = ~place;
        if ($urandom_range(0, 19) == 0) destroy = ~destroy;
        tx_ready = ($urandom_range(0, 3) != 0);
        rx_valid = ($urandom_range(0, 15) == 0);
        rx_data  = 8'($urandom_range(0, 255));
    endtask

    initial begin
        //  reps gs pon poff cl thr br rg l r as am       pw sl      ml       tl tr
        add(7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);
        add(7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 3'b001, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'h0, 1, 3'b010, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 1, 3'b100, 4'b0001, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4'h0, 1, 3'b100, 4'b0101, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'h0, 1, 3'b100, 4'b1001, 0, 1);
        add(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 4'h0, 1, 3'b010, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'h0, 1, 3'b100, 4'b0010, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1, 3'b010, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 4'h0, 1, 3'b001, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);
        add(8, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 1, 3'b001, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 4'h0, 1, 3'b010, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4'h0, 1, 3'b100, 4'b0010, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);
        add(8, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);
        add(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 3'b001, 4'b0000, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4'hA, 1, 3'b111, 4'b1010, 0, 0);
        add(3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 3'b111, 4'b1010, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4'h6, 1, 3'b100, 4'b0110, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 3'b001, 4'b0000, 0, 0);
        add(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 4'h0, 1, 3'b010, 4'b0000, 1, 0);
        add(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 3'b010, 4'b0000, 1, 0);
        add(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 3'b000, 4'b0000, 0, 0);

        rst = 0;
        clear_inputs();
        tick();
        check("reset tx_valid", tx_valid, 0);
        check("reset tx_data", tx_data, 0);
        check("reset detector", detector, 0);
        check("reset power_light", power_light, 0);
        check("reset state_light", state_light, 0);
        check("reset moving_light", moving_light, 0);
        check("reset turn lights", {turn_left_light, turn_right_light}, 0);
        tick();
        rst = 1;

        foreach (vecs[i]) begin
            global_state = vecs[i].gs; power_on = vecs[i].pon; power_off = vecs[i].poff;
            clutch = vecs[i].cl; throttle = vecs[i].thr; brake = vecs[i].br;
            rgs = vecs[i].rg; left = vecs[i].l; right = vecs[i].r;
            auto_state = vecs[i].as; auto_moving = vecs[i].am;
            repeat (vecs[i].reps) tick();
            check($sformatf("vec%0d power_light", i), power_light, vecs[i].pw);
            check($sformatf("vec%0d state_light", i), state_light, vecs[i].sl);
            check($sformatf("vec%0d moving_light", i), moving_light, vecs[i].ml);
            check($sformatf("vec%0d turn lights", i), {turn_left_light, turn_right_light},
                  {vecs[i].tl, vecs[i].tr});
        end

        // Idle link: heartbeat frames and detector timeout from a clean reset.
        clear_inputs();
        do_reset();
        for (int k = 1; k <= 3 * PER; k++) begin
            tick();
            check($sformatf("heartbeat cycle %0d", k), tx_valid, (k % PER == 0));
            if (k == STALE - 1) check("detector before timeout", detector, 4'h0);
            if (k == STALE)     check("detector at timeout", detector, 4'hF);
        end
        rx_valid = 1; rx_data = 8'h53;
        tick();
        check("detector latch", detector, 4'h3);
        rx_valid = 0;
        repeat (STALE - 1) tick();
        check("detector held before timeout", detector, 4'h3);
        rx_valid = 1; rx_data = 8'hFC;
        tick();
        check("rx wins over timeout", detector, 4'hC);
        rx_valid = 0;
        repeat (STALE - 1) tick();
        check("detector held again", detector, 4'hC);
        tick();
        check("detector forced again", detector, 4'hF);

        // Coalescing while the link is stalled, then back-to-back handshake.
        clear_inputs();
        tx_ready = 0;
        do_reset();
        place = 1;
        tick();
        check("first frame valid", tx_valid, 1);
        check("first frame data", tx_data, 8'h90);
        destroy = 1;
        tick();
        check("stalled data stable 1", tx_data, 8'h90);
        place = 0;
        tick();
        check("stalled data stable 2", tx_data, 8'h90);
        repeat (2) tick();
        check("stalled valid held", tx_valid, 1);
        check("stalled data stable 3", tx_data, 8'h90);
        tx_ready = 1;
        tick();
        check("coalesced frame no drop", tx_valid, 1);
        check("coalesced frame newest", tx_data, 8'hA0);
        tick();
        check("valid drops after accept", tx_valid, 0);
        place = 1;
        tick();
        check("new frame valid", tx_valid, 1);
        check("new frame data", tx_data, 8'hB0);
        place = 0;
        tick();
        check("back-to-back valid", tx_valid, 1);
        check("back-to-back data", tx_data, 8'hA0);
        tick();
        check("back-to-back drop", tx_valid, 0);

        // Asynchronous reset in the middle of a pending frame.
        tx_ready = 0; place = 1;
        tick();
        check("pending before reset", tx_valid, 1);
        #2 rst = 0;
        #1;
        check("async reset tx_valid", tx_valid, 0);
        check("async reset tx_data", tx_data, 0);
        tick();
        clear_inputs();
        rst = 1;

        clear_inputs();
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            m_step();
            tick();
            check($sformatf("random cycle %0d", c),
                  {power_light, state_light, moving_light, turn_left_light, turn_right_light,
                   tx_valid, tx_data, detector},
                  {m_power, (m_power ? lamp(m_code) : 3'b000), (m_power ? m_mov : 4'b0000),
                   m_power & m_tl, m_power & m_tr, m_pend, m_data, m_det});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
